// File: rtl/maltsev_pkg.sv
// maltsev_pkg: shared widths and call-controller state encoding,
// common to maltsev_call_ctrl and the generated root_* wrappers.
package maltsev_pkg;

  localparam int W_DEF = 16;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_START = 3'd1;
  localparam logic [2:0] ENC_WAIT  = 3'd2;
  localparam logic [2:0] ENC_HOLD  = 3'd3;
  localparam logic [2:0] ENC_ERROR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ENC_IDLE,
    S_START = ENC_START,
    S_WAIT  = ENC_WAIT,
    S_HOLD  = ENC_HOLD,
    S_ERROR = ENC_ERROR
  } state_e;

endpackage

// File: rtl/maltsev_call_timer.sv
// maltsev_call_timer: bounded wait counter with clear/enable;
// expire_o is high once TIMEOUT-1 enabled cycles have elapsed.
module maltsev_call_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expire_o = (cnt_q == TW'(TIMEOUT - 1));

  // Clear wins over enable; the count holds once expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/maltsev_call_ctrl.sv
// maltsev_call_ctrl: drives one ST/RD/RES call into a root_*
// operator tree and returns RES downstream under valid/ack.
module maltsev_call_ctrl
  import maltsev_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ,
  output logic          ACK,
  input  logic [W-1:0]  A0,
  input  logic [W-1:0]  A1,
  input  logic [W-1:0]  A2,
  input  logic [W-1:0]  A3,
  input  logic [W-1:0]  A4,
  output logic          ST,
  input  logic          RD,
  input  logic [W-1:0]  RES,
  output logic [W-1:0]  IN0,
  output logic [W-1:0]  IN1,
  output logic [W-1:0]  IN2,
  output logic [W-1:0]  IN3,
  output logic [W-1:0]  IN4,
  output logic [W-1:0]  OUT,
  output logic          OUT_VLD,
  input  logic          OUT_ACK,
  output logic          ERR,
  input  logic          CLR,
  output logic          BUSY,
  output logic [CW-1:0] CNT
);

  state_e         state_q, state_d;
  logic           ack_q, ack_d;
  logic           st_q, st_d;
  logic           vld_q, vld_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           rd_q;
  logic [W-1:0]   out_q, out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   in_q [5];
  logic [W-1:0]   in_d [5];
  logic           done;
  logic           expire;

  // Only a fresh rising edge of RD completes a call.
  assign done = RD & ~rd_q;

  maltsev_call_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr_i    (state_q == S_START),
    .en_i     ((state_q == S_WAIT) && !done),
    .expire_o (expire)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    vld_d   = vld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ && ack_q) begin
          in_d    = '{A0, A1, A2, A3, A4};
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done) begin
          out_d   = RES;
          vld_d   = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_HOLD;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_HOLD: begin
        if (OUT_ACK) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (CLR) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    st_d   = (state_d == S_START);
    ack_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any call in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      st_q    <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      in_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      st_q    <= st_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rd_q    <= RD;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
    end
  end

  assign ACK     = ack_q;
  assign ST      = st_q;
  assign OUT     = out_q;
  assign OUT_VLD = vld_q;
  assign ERR     = err_q;
  assign BUSY    = busy_q;
  assign CNT     = cnt_q;
  assign IN0     = in_q[0];
  assign IN1     = in_q[1];
  assign IN2     = in_q[2];
  assign IN3     = in_q[3];
  assign IN4     = in_q[4];

endmodule

// File: tb/tb_maltsev_call_ctrl.sv
// tb_maltsev_call_ctrl: directed and randomized calls through a
// summing stub operator, checked against a call-level model.
module tb_maltsev_call_ctrl;

  logic        CLK;
  logic        RST;
  logic        REQ;
  logic        ACK;
  logic [15:0] A0, A1, A2, A3, A4;
  logic        ST;
  logic        RD;
  logic [15:0] RES;
  logic [15:0] IN0, IN1, IN2, IN3, IN4;
  logic [15:0] OUT;
  logic        OUT_VLD;
  logic        OUT_ACK;
  logic        ERR;
  logic        CLR;
  logic        BUSY;
  logic [3:0]  CNT;

  int n_chk;
  int n_fail;
  int mcnt;
  int stub_lat;
  int stub_drop;
  int t;

  maltsev_call_ctrl #(
    .W       (16),
    .TIMEOUT (16),
    .CW      (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .ACK     (ACK),
    .A0      (A0),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .A4      (A4),
    .ST      (ST),
    .RD      (RD),
    .RES     (RES),
    .IN0     (IN0),
    .IN1     (IN1),
    .IN2     (IN2),
    .IN3     (IN3),
    .IN4     (IN4),
    .OUT     (OUT),
    .OUT_VLD (OUT_VLD),
    .OUT_ACK (OUT_ACK),
    .ERR     (ERR),
    .CLR     (CLR),
    .BUSY    (BUSY),
    .CNT     (CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Stub operator: counts edges after seeing ST, lowers RD at
  // stub_drop, raises RD with the input sum at stub_lat (0 = never).
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RD  <= 1'b0;
      RES <= '0;
      t   <= 0;
    end else if (ST) begin
      t <= 1;
    end else if (t != 0) begin
      if (t == stub_drop) RD <= 1'b0;
      if (t == stub_lat) begin
        RD  <= 1'b1;
        RES <= IN0 + IN1 + IN2 + IN3 + IN4;
        t   <= 0;
      end else begin
        t <= t + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete call: accept, wait lat+2 edges for OUT_VLD,
  // hold for `hold` cycles with REQ/CLR noise, then acknowledge.
  task automatic call(input logic [15:0] a0, a1, a2, a3, a4,
                      input int lat, input int drop, input int hold);
    logic [15:0] s;
    s = a0 + a1 + a2 + a3 + a4;
    stub_lat  = lat;
    stub_drop = drop;
    chk("ack_idle", 32'(ACK), 1);
    A0 = a0; A1 = a1; A2 = a2; A3 = a3; A4 = a4;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    chk("st_pulse", 32'(ST), 1);
    chk("ack_taken", 32'(ACK), 0);
    chk("busy", 32'(BUSY), 1);
    chk("in0", 32'(IN0), 32'(a0));
    chk("in1", 32'(IN1), 32'(a1));
    chk("in2", 32'(IN2), 32'(a2));
    chk("in3", 32'(IN3), 32'(a3));
    chk("in4", 32'(IN4), 32'(a4));
    for (int n = 1; n <= lat + 2; n++) begin
      tick();
      chk("st_low", 32'(ST), 0);
      if (n < lat + 2) chk("vld_early", 32'(OUT_VLD), 0);
    end
    mcnt = (mcnt + 1) % 16;
    chk("vld", 32'(OUT_VLD), 1);
    chk("out", 32'(OUT), 32'(s));
    chk("cnt", 32'(CNT), mcnt);
    chk("err_ok", 32'(ERR), 0);
    REQ = 1'b1;
    CLR = 1'b1;
    A0 = 16'($urandom);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("vld_hold", 32'(OUT_VLD), 1);
      chk("out_hold", 32'(OUT), 32'(s));
      chk("ack_hold", 32'(ACK), 0);
      chk("in_hold", 32'(IN0), 32'(a0));
    end
    REQ = 1'b0;
    CLR = 1'b0;
    OUT_ACK = 1'b1;
    tick();
    OUT_ACK = 1'b0;
    chk("vld_drop", 32'(OUT_VLD), 0);
    chk("ack_back", 32'(ACK), 1);
    chk("busy_off", 32'(BUSY), 0);
  endtask

  initial begin
    int d;
    int l;
    int h;
    n_chk = 0;
    n_fail = 0;
    mcnt = 0;
    stub_lat = 3;
    stub_drop = 1;
    RST = 1'b0;
    REQ = 1'b0;
    OUT_ACK = 1'b0;
    CLR = 1'b0;
    A0 = '0; A1 = '0; A2 = '0; A3 = '0; A4 = '0;

    tick();
    tick();
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_st", 32'(ST), 0);
    chk("rst_vld", 32'(OUT_VLD), 0);
    chk("rst_out", 32'(OUT), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_cnt", 32'(CNT), 0);
    chk("rst_in0", 32'(IN0), 0);
    RST = 1'b1;
    chk("rel_ack_wait", 32'(ACK), 0);
    tick();
    chk("rel_ack", 32'(ACK), 1);

    // Basic call with long downstream backpressure.
    call(16'd2, 16'd3, 16'd3, 16'd2, 16'd3, 3, 1, 20);
    // RD left high: must drop and rise again before completion.
    call(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 4, 2, 0);
    // Done on the same edge as the timeout: done wins.
    call(16'hFFFF, 16'd7, 16'h8000, 16'd1, 16'h1234, 15, 1, 1);

    // Timeout with a stale-high RD that never moves.
    stub_lat = 0;
    stub_drop = 0;
    A0 = 16'd7;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk("to_vld", 32'(OUT_VLD), 0);
      if (n < 17) chk("to_err_early", 32'(ERR), 0);
      else chk("to_err", 32'(ERR), 1);
    end
    A0 = 16'd9;
    REQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("err_ack", 32'(ACK), 0);
      chk("err_st", 32'(ST), 0);
      chk("err_hold", 32'(ERR), 1);
      chk("err_in0", 32'(IN0), 7);
    end
    REQ = 1'b0;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_err", 32'(ERR), 0);
    chk("clr_ack", 32'(ACK), 1);
    chk("clr_busy", 32'(BUSY), 0);
    chk("clr_cnt", 32'(CNT), mcnt);

    // Randomized calls.
    for (int i = 0; i < 5; i++) begin
      d = int'($urandom_range(1, 3));
      l = int'($urandom_range(d + 1, 15));
      h = int'($urandom_range(0, 4));
      call(16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), l, d, h);
    end

    // Asynchronous reset while waiting on the operator.
    stub_lat = 12;
    stub_drop = 1;
    A0 = 16'd5;
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    tick();
    tick();
    tick();
    #2;
    RST = 1'b0;
    #1;
    mcnt = 0;
    chk("ar_st", 32'(ST), 0);
    chk("ar_vld", 32'(OUT_VLD), 0);
    chk("ar_cnt", 32'(CNT), 0);
    chk("ar_busy", 32'(BUSY), 0);
    chk("ar_ack", 32'(ACK), 0);
    chk("ar_in0", 32'(IN0), 0);
    tick();
    RST = 1'b1;
    tick();
    chk("ar_rel_ack", 32'(ACK), 1);

    // Fresh call then 16 more: CNT wraps back to 1.
    call(16'd2, 16'd3, 16'd3, 16'd2, 16'd3, 3, 1, 2);
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(1, 2));
      l = int'($urandom_range(d + 1, 6));
      call(16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), l, d, 0);
    end
    chk("wrap", 32'(CNT), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
